muldiv_sched_ctrl: RTL

- Scheduler and sequencer for the shared iterative multiply/divide datapath (product/remainder register, ADDU ALU, shift unit).
- Arbitrates two requesters (e.g. two issue slots) with round-robin fairness and loads the selected operands.
- Sequences WIDTH shift-add multiply iterations or WIDTH restoring-divide iterations, then returns a per-requester done pulse.

---
 rtl/muldiv_sched_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/muldiv_sched_ctrl.sv
// Round-robin scheduler and sequencer for the shared iterative multiply/divide datapath.
// Grants one of two requesters, loads operands, steps the datapath, and pulses done.
module muldiv_sched_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [1:0] op,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       sel,
  input  logic       LSB,
  input  logic       Rem_sign,
  output logic       W_ctrl,
  output logic [5:0] ALU_ctrl,
  output logic       SRL_ctrl,
  output logic       SLL_ctrl,
  output logic       Qbit,
  output logic       Restore_ctrl
);

  localparam logic [5:0] ALU_IDLE = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b001001;
  localparam logic [5:0] ALU_SUB  = 6'b001010;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_STEP,
    S_DIV_SHIFT,
    S_DIV_SUB,
    S_DIV_CHK,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ptr, ptr_next;
  logic             sel_q, sel_next;
  logic             op_q, op_next;
  logic             pick;
  logic [1:0]       sel_onehot;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
      sel_q <= 1'b0;
      op_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
      sel_q <= sel_next;
      op_q  <= op_next;
    end
  end

  // A lone requester wins outright; on contention the pointer decides.
  assign pick       = (req == 2'b10) ? 1'b1 : ((req == 2'b11) ? ptr : 1'b0);
  assign sel_onehot = sel_q ? 2'b10 : 2'b01;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ptr_next     = ptr;
    sel_next     = sel_q;
    op_next      = op_q;
    gnt          = 2'b00;
    done         = 2'b00;
    busy         = 1'b1;
    sel          = sel_q;
    W_ctrl       = 1'b0;
    ALU_ctrl     = ALU_IDLE;
    SRL_ctrl     = 1'b0;
    SLL_ctrl     = 1'b0;
    Qbit         = 1'b0;
    Restore_ctrl = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        sel  = 1'b0;
        if (|req) begin
          sel_next   = pick;
          op_next    = op[pick];
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        W_ctrl     = 1'b1;
        gnt        = sel_onehot;
        cnt_next   = '0;
        ptr_next   = ~sel_q;
        state_next = op_q ? S_DIV_SHIFT : S_MUL_STEP;
      end
      S_MUL_STEP: begin
        SRL_ctrl = 1'b1;
        ALU_ctrl = LSB ? ALU_ADD : ALU_IDLE;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ITER) state_next = S_DONE;
      end
      S_DIV_SHIFT: begin
        SLL_ctrl   = 1'b1;
        state_next = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        ALU_ctrl   = ALU_SUB;
        state_next = S_DIV_CHK;
      end
      S_DIV_CHK: begin
        // A negative remainder is restored in the same cycle the zero quotient bit shifts in.
        SLL_ctrl = 1'b1;
        Qbit     = ~Rem_sign;
        if (Rem_sign) begin
          ALU_ctrl     = ALU_ADD;
          Restore_ctrl = 1'b1;
        end
        cnt_next   = cnt + 1'b1;
        state_next = (cnt == LAST_ITER) ? S_DONE : S_DIV_SUB;
      end
      S_DONE: begin
        done       = sel_onehot;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        sel        = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
